// File: rtl/mem_req_issue_ctrl.sv
// Request-queuing memory stage: buffers write/read requests in an in-order FIFO,
// issues them as single-cycle strobes and answers reads from a flagged backing memory.
module mem_req_issue_ctrl #(
  parameter int AW     = 4,
  parameter int DW     = 32,
  parameter int QDEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [AW-1:0]                req_addr,
  input  logic [DW-1:0]                req_wdata,
  output logic                         write,
  output logic                         read,
  output logic [31:0]                  addr,
  output logic [31:0]                  wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DW-1:0]                rsp_data,
  output logic                         rsp_err,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  cmd_t            fifo [QDEPTH];
  logic [DW-1:0]   mem  [2**AW];
  logic [2**AW-1:0] flag;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  cmd_t            head;
  logic            push, pop;
  logic [AW-1:0]   idx;
  rsp_state_t      rsp_state;

  assign req_ready = reset_n && (q_count < FULL_CNT);
  assign push      = req_valid && req_ready;
  assign head      = fifo[rd_ptr];
  assign idx       = addr[AW-1:0];
  assign rsp_valid = (rsp_state == RSP_FULL);

  // A read may only leave the queue when its response slot will be free at the
  // edge it ends, so reads never stack and never overwrite an unconsumed response.
  assign pop = (q_count != '0) &&
               (head.wr || (!read && (!rsp_valid || rsp_ready)));

  // NOTE: storage arrays carry no reset; validity comes from pointers and flags only.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= {req_write, req_addr, req_wdata};
    if (write) mem[idx] <= wdata[DW-1:0];
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      write   <= 1'b0;
      read    <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: ;
      endcase
      write <= pop && head.wr;
      read  <= pop && !head.wr;
      if (pop) begin
        addr  <= 32'(head.a);
        wdata <= head.wr ? 32'(head.d) : 32'h0;
      end
    end
  end

  // Written flags commit on the same edge as the memory word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flag <= '0;
    else if (write) flag[idx] <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_state <= RSP_EMPTY;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (read) begin
      rsp_state <= RSP_FULL;
      rsp_data  <= flag[idx] ? mem[idx] : '0;
      rsp_err   <= !flag[idx];
    end else if (rsp_state == RSP_FULL && rsp_ready) begin
      rsp_state <= RSP_EMPTY;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_issue_ctrl.sv
// Scoreboard bench for mem_req_issue_ctrl: expected strobes and responses are
// queued at request acceptance from a bench-side memory model.
module tb_mem_req_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        write, read;
  logic [31:0] addr, wdata;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  q_count;

  mem_req_issue_ctrl #(.AW(4), .DW(32), .QDEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .write(write), .read(read), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } stb_t;
  typedef struct packed { logic [31:0] data; logic err; } rsp_t;

  stb_t        exp_stb [$];
  rsp_t        exp_rsp [$];
  logic [31:0] m_mem  [16];
  bit          m_flag [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        prev_read = 1'b0;
  stb_t        got_s;
  rsp_t        got_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input bit w, input int a, input logic [31:0] d);
    int t = 0;
    req_valid = 1'b1; req_write = w; req_addr = 4'(a); req_wdata = d;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("send_timeout", 0, 1);
    end else if (w) begin
      exp_stb.push_back('{w: 1'b1, a: 32'(a), d: d});
      m_mem[a] = d;
      m_flag[a] = 1'b1;
    end else begin
      exp_stb.push_back('{w: 1'b0, a: 32'(a), d: 32'h0});
      exp_rsp.push_back('{data: m_flag[a] ? m_mem[a] : 32'h0, err: !m_flag[a]});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_stb.size() == 0 && exp_rsp.size() == 0 && q_count == 0 &&
          !rsp_valid && !read && !write) done = 1'b1;
      else @(negedge clk);
    end
    check("drain", done, 1);
  endtask

  task automatic set_rsp_ready(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write"}, write, 0);
    check({tag, "_read"}, read, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_q_count"}, q_count, 0);
    check({tag, "_req_ready"}, req_ready, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("q_count_max", q_count <= 3'd4, 1);
      if (write || read) begin
        if (exp_stb.size() == 0) begin
          check("unexpected_strobe", {write, read}, 0);
        end else begin
          got_s = exp_stb.pop_front();
          check("stb_kind", {write, read}, {got_s.w, !got_s.w});
          check("stb_addr", addr, got_s.a);
          check("stb_wdata", wdata, got_s.d);
        end
        if (read) check("read_gap", prev_read, 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          got_r = exp_rsp.pop_front();
          check("rsp_data", rsp_data, got_r.data);
          check("rsp_err", rsp_err, got_r.err);
        end
      end
      prev_read = read;
    end else begin
      prev_read = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (m_flag[i]) m_flag[i] = 1'b0;

    // Reset state and release
    #12 check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("release_req_ready", req_ready, 1);
    @(negedge clk);

    // Read of an unwritten word
    send(0, 3, 0);
    @(negedge clk);
    check("t1_read", read, 1);
    check("t1_addr", addr, 3);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_err", rsp_err, 1);
    check("t1_rsp_data", rsp_data, 0);
    drain();

    // Write then back-to-back read of the same word
    send(1, 5, 32'hDEADBEEF);
    send(0, 5, 0);
    check("t2_write", write, 1);
    check("t2_wdata", wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t2_read_next", read, 1);
    check("t2_read_addr", addr, 5);
    check("t2_read_wdata", wdata, 0);
    @(negedge clk);
    check("t2_rsp_data", rsp_data, 32'hDEADBEEF);
    check("t2_rsp_err", rsp_err, 0);
    drain();

    // Fill the FIFO behind a stalled response
    for (int i = 0; i < 6; i++) send(1, 8 + i, 32'hC0DE_0000 + 32'(i));
    drain();
    set_rsp_ready(1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, 8 + i, 0);
      end
      begin
        int t = 0;
        while (q_count != 3'd4 && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("t3_full_count", q_count, 4);
        check("t3_full_ready", req_ready, 0);
        repeat (3) @(negedge clk);
        check("t3_held_count", q_count, 4);
        check("t3_held_ready", req_ready, 0);
        check("t3_held_valid", req_valid, 1);
        set_rsp_ready(1'b1);
      end
    join
    drain();

    // Consecutive reads with rsp_ready high
    send(0, 5, 0);
    send(0, 9, 0);
    send(0, 2, 0);
    drain();

    // Write all 16 words back-to-back, then read them all back
    for (int i = 0; i < 16; i++) send(1, i, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 16; i++) send(0, i, 0);
    drain();

    // Reset with a read strobe in flight and two entries queued
    for (int i = 0; i < 4; i++) send(0, 7, 0);
    check("t6_read_high", read, 1);
    check("t6_queued", q_count, 2);
    #1 reset_n = 1'b0;
    exp_stb.delete();
    exp_rsp.delete();
    foreach (m_flag[i]) m_flag[i] = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    check_all_zero("held_reset");
    reset_n = 1'b1;
    #1 check("t6_release_ready", req_ready, 1);
    @(negedge clk);
    send(0, 7, 0);
    repeat (2) @(negedge clk);
    check("t6_rsp_valid", rsp_valid, 1);
    check("t6_rsp_err", rsp_err, 1);
    check("t6_rsp_data", rsp_data, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
